latch_rr_sched: RTL and testbench
=================================

Name: latch_rr_sched

Overview:
Round-robin scheduler that shares one 4-bit capture latch between four requesters. It uses a 4-bit Johnson counter as the grant-window timer. A granted requester holds the latch for one full Johnson cycle, 8 clocks. Its data is then captured into data_out and the requester receives a one-cycle ack. The block sits in front of the capture-latch datapath and replaces per-requester latches.

Parameters:
N_REQ, 4, number of requesters; fixed at 4 for this revision, and RTL may reject other values.
DW, 4, data width per requester and width of data_out.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
req  input  N_REQ  request per requester; level, held until ack or abandon
data_in  input  N_REQ*DW  packed requester data; requester i occupies bits [i*DW +: DW]
grant  output  N_REQ  one-hot grant, registered
ack  output  N_REQ  one-cycle completion pulse, registered
data_out  output  DW  captured data of the last completed grant
jcnt_out  output  4  Johnson counter state, the window phase
busy  output  1  high in GRANT and DONE

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; grant=0, ack=0, data_out=0, jcnt_out=0000, busy=0.
  - rr pointer=0, so requester 0 has highest priority first.
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If req != 0 at a rising edge: pick the first set req bit scanning from ptr upward, modulo 4.
  - At that edge: grant <= onehot(winner), state <= GRANT, jcnt <= 0000, ptr <= winner+1 (mod 4).
  - If req == 0: stay in IDLE, all outputs hold.
- GRANT:
  - Johnson counter advances one step per clock, only in GRANT.
  - Sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 (shift left, feed back ~msb).
  - Normal completion, at the edge where jcnt==1000 and req[winner]=1:
    - state <= DONE, data_out <= data_in slice of winner, ack[winner] <= 1, grant <= 0, jcnt <= 0000.
  - Abort, at any GRANT edge where req[winner]=0:
    - state <= IDLE, grant <= 0, jcnt <= 0000.
    - No ack; data_out unchanged; ptr keeps its advanced value.
  - Abort takes precedence over completion on the same edge.
  - grant is high for exactly 8 cycles on a normal completion.
  - Requests from other requesters during GRANT are ignored (not pre-empted).
- DONE:
  - Lasts one cycle; ack is high only in this cycle.
  - Next edge: ack <= 0, state <= IDLE.
  - Minimum per-grant period is 10 cycles (IDLE 1 + GRANT 8 + DONE 1).
- data_in is sampled only on the completion edge; changes during the window are invisible.
- busy = (state != IDLE), decoded from the registered state.
- Async reset asserted mid-GRANT or mid-DONE clears everything immediately, including any pending ack.
- Fairness: with all 4 requesters continuously requesting, grants go 0,1,2,3,0,…

Decomposition:
- Shared package latch_sched_pkg:
  - state encoding constants S_IDLE=2'd0, S_GRANT=2'd1, S_DONE=2'd2.
  - JCNT_LAST=4'b1000.
  - DW and N_REQ defaults.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: winner[1:0], any.
- The Johnson counter stays inline in the top level.

Test Plan:
- Reset: n_rst=0 with req=4'b1111 → grant=0, ack=0, data_out=0000, jcnt_out=0000, busy=0 throughout.
- Single request: release reset; req=4'b0100, data_in slice2=4'b1101.
  - grant=0100 for 8 cycles.
  - jcnt_out walks 0000→…→1000.
  - Then ack=0100 for 1 cycle and data_out=1101.
  - Drop req after ack → IDLE, busy=0.
- Round robin: req=4'b1111 held, slices {3:0011, 2:1001, 1:0001, 0:0101}.
  - Acks in order 0001, 0010, 0100, 1000, then 0001 again.
  - data_out sequence 0101, 0001, 1001, 0011.
  - Acks are 10 cycles apart.
- Abort: grant requester 1, drop req[1] when jcnt_out=0111.
  - Next edge: grant=0, jcnt_out=0000, no ack, data_out keeps its previous value.
  - The following grant goes to requester 2 if it is requesting.
- Late data change: data_in slice0 changes 0001→0010 at jcnt_out=1100 and stays 0010 → data_out=0010 at DONE.
  - Changes before the completion edge are otherwise ignored.
- Reset mid-window: assert n_rst=0 at jcnt_out=1110 → all outputs 0 asynchronously, no ack.
  - After release, with req=4'b1010, requester 1 is granted first (ptr reset to 0).

Source files
------------

// File: rtl/latch_sched_pkg.sv
// Shared types and constants for the round-robin capture-latch scheduler.
package latch_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Final phase of the grant window; completion happens on the edge that sees it.
  localparam logic [3:0] JCNT_LAST = 4'b1000;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [3:0] jcnt_step(input logic [3:0] j);
    return {j[2:0], ~j[3]};
  endfunction

endpackage

// File: rtl/latch_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, modulo 4.
// Zero latency; no flow control.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] rot;
  logic [1:0] off;

  // Rotate so that the pointer position lands on bit 0.
  always_comb begin
    rot = req;
    case (ptr)
      2'd1:    rot = {req[0],   req[3:1]};
      2'd2:    rot = {req[1:0], req[3:2]};
      2'd3:    rot = {req[2:0], req[3]};
      default: rot = req;
    endcase
  end

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign winner = ptr + off;
  assign any    = |req;

endmodule

// File: rtl/latch_rr_sched.sv
// Round-robin scheduler sharing one capture latch between four requesters, 8-clock Johnson window.
// Grant one edge after request; ack + data_out 8 clocks later; requester may abandon by dropping req.
module latch_rr_sched
  import latch_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_in,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       data_out,
  output logic [3:0]          jcnt_out,
  output logic                busy
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q,   ack_d;
  logic [DW-1:0]    data_q,  data_d;
  logic [3:0]       jcnt_q,  jcnt_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [1:0]       win_q,   win_d;

  logic [1:0]       pick_win;
  logic             pick_any;
  logic [DW-1:0]    slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = data_in[i*DW +: DW];
  end

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      jcnt_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      jcnt_q  <= jcnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    jcnt_d  = jcnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_GRANT;
          grant_d = onehot4(pick_win);
          jcnt_d  = '0;
          ptr_d   = pick_win + 2'd1;
          win_d   = pick_win;
        end
      end
      S_GRANT: begin
        // Abandon wins over completion; the pointer stays advanced either way.
        if (!req[win_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          jcnt_d  = '0;
        end else if (jcnt_q == JCNT_LAST) begin
          state_d = S_DONE;
          grant_d = '0;
          jcnt_d  = '0;
          ack_d   = onehot4(win_q);
          data_d  = slice[win_q];
        end else begin
          jcnt_d  = jcnt_step(jcnt_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign data_out = data_q;
  assign jcnt_out = jcnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_latch_rr_sched.sv
// Scoreboard bench for latch_rr_sched: stimulus pushes expected grants/acks, a negedge monitor pops and compares.
module tb_latch_rr_sched;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [3:0]  data_out;
  logic [3:0]  jcnt_out;
  logic        busy;

  latch_rr_sched dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .ack      (ack),
    .data_out (data_out),
    .jcnt_out (jcnt_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] data;
    int         gap;
  } ack_exp_t;

  ack_exp_t   exp_ack[$];
  logic [3:0] exp_grant[$];

  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int ack_seen     = 0;
  int last_ack_cyc = 0;
  int target       = 0;

  logic [3:0] prev_grant = 4'b0;
  logic [3:0] g_pop;
  ack_exp_t   a_pop;

  logic [3:0] jseq  [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] rr_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_d  [5] = '{4'b0101, 4'b0001, 4'b1001, 4'b0011, 4'b0101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic [3:0] a, input logic [3:0] d, input int gap);
    ack_exp_t e;
    e.ack  = a;
    e.data = d;
    e.gap  = gap;
    exp_ack.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_jcnt(input logic [3:0] v, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (jcnt_out == v) hit = 1'b1;
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  task automatic wait_acks(input int tgt, input string nm);
    for (int i = 0; i < 200 && ack_seen < tgt; i++) tick();
    chk(nm, 32'(ack_seen >= tgt), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each new grant and each ack against the scoreboard queues.
  always @(negedge clk) begin
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      if (exp_grant.size() == 0) chk("grant_unexpected", 32'(grant), 32'd0);
      else begin
        g_pop = exp_grant.pop_front();
        chk("grant_order", 32'(grant), 32'(g_pop));
      end
    end
    prev_grant = grant;
    if (ack != 4'b0) begin
      if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
      else begin
        a_pop = exp_ack.pop_front();
        chk("ack_vec", 32'(ack), 32'(a_pop.ack));
        chk("ack_data", 32'(data_out), 32'(a_pop.data));
        if (a_pop.gap != 0) chk("ack_gap", 32'(cyc - last_ack_cyc), 32'(a_pop.gap));
      end
      last_ack_cyc = cyc;
      ack_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst   = 1'b0;
    req     = 4'b1111;
    data_in = 16'h0000;
    repeat (3) tick();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_ack",   32'(ack), 32'd0);
    chk("reset_dout",  32'(data_out), 32'd0);
    chk("reset_jcnt",  32'(jcnt_out), 32'd0);
    chk("reset_busy",  32'(busy), 32'd0);

    // Single requester 2
    req     = 4'b0100;
    data_in = 16'h0D00;
    exp_grant.push_back(4'b0100);
    push_ack(4'b0100, 4'b1101, 0);
    n_rst   = 1'b1;
    tick();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_jcnt0", 32'(jcnt_out), 32'h0);
    chk("single_busy",  32'(busy), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("single_jcnt", 32'(jcnt_out), 32'(jseq[k]));
      chk("single_grant_hold", 32'(grant), 32'h4);
    end
    tick();
    chk("single_ack",       32'(ack), 32'h4);
    chk("single_dout",      32'(data_out), 32'hD);
    chk("single_grant_off", 32'(grant), 32'h0);
    chk("single_done_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    tick();
    chk("single_ack_off", 32'(ack), 32'h0);
    chk("single_idle",    32'(busy), 32'd0);
    tick();
    chk("single_no_regrant", 32'(grant), 32'h0);

    // Round robin from a fresh pointer
    n_rst = 1'b0;
    tick();
    n_rst   = 1'b1;
    data_in = 16'h3915;
    for (int k = 0; k < 5; k++) begin
      exp_grant.push_back(rr_g[k]);
      push_ack(rr_g[k], rr_d[k], (k == 0) ? 0 : 10);
    end
    target = ack_seen + 5;
    req    = 4'b1111;
    wait_acks(target, "rr_timeout");
    req = 4'b0000;
    tick();

    // Abandon by requester 1, then requester 2 is next
    data_in = 16'h0900;
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100);
    push_ack(4'b0100, 4'b1001, 0);
    req = 4'b0110;
    wait_jcnt(4'b0111, "abort_wait");
    req = 4'b0100;
    tick();
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_jcnt",  32'(jcnt_out), 32'h0);
    chk("abort_ack",   32'(ack), 32'h0);
    chk("abort_dout",  32'(data_out), 32'h5);
    chk("abort_busy",  32'(busy), 32'd0);
    target = ack_seen + 1;
    wait_acks(target, "abort_next_timeout");
    req = 4'b0000;
    tick();

    // Data is only sampled on the completion edge
    data_in = 16'h0001;
    exp_grant.push_back(4'b0001);
    push_ack(4'b0001, 4'b0010, 0);
    req = 4'b0001;
    wait_jcnt(4'b0011, "late_w1");
    data_in = 16'h000F;
    wait_jcnt(4'b0111, "late_w2");
    data_in = 16'h0001;
    wait_jcnt(4'b1100, "late_w3");
    data_in = 16'h0002;
    target  = ack_seen + 1;
    wait_acks(target, "late_timeout");
    req = 4'b0000;
    tick();

    // Reset in the middle of a window
    data_in = 16'h00A0;
    exp_grant.push_back(4'b1000);
    req = 4'b1000;
    wait_jcnt(4'b1110, "rst_wait");
    n_rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_jcnt",  32'(jcnt_out), 32'h0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_dout",  32'(data_out), 32'h0);
    tick();
    req = 4'b1010;
    exp_grant.push_back(4'b0010);
    push_ack(4'b0010, 4'b1010, 0);
    n_rst  = 1'b1;
    target = ack_seen + 1;
    wait_acks(target, "rst_after_timeout");
    req = 4'b0000;
    repeat (3) tick();

    chk("grant_queue_left", 32'(exp_grant.size()), 32'd0);
    chk("ack_queue_left",   32'(exp_ack.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
